// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte holding buffer, sticky overrun and a framing-error pulse.
// The line is sampled mid-bit using a baud counter that restarts at each sample point.
module uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clock_50MHz,
    input  logic       reset,
    input  logic       UART_Rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          ferr_q, ferr_d;
    logic          stop_ok, stop_bad;
    logic          line;

    assign line = sync2_q;

    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            sync1_q   <= UART_Rx;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                if (!line) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = line ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {line, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    stop_ok  = line;
                    stop_bad = !line;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer policy: an ack in the delivery cycle frees the slot for the new byte.
    always_comb begin
        busy      = (state_q != IDLE);
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        ferr_d    = stop_bad;
        if (rx_ack && overrun_q) overrun_d = 1'b0;
        if (stop_ok) begin
            if (!valid_q || rx_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack && valid_q) begin
            valid_d = 1'b0;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed checks of uart_rx against a byte-level model of the
// holding buffer (data / valid / overrun) and of frame timing.
module tb_uart_rx;

    localparam int BIT = 434;

    logic       clk = 1'b0;
    logic       reset;
    logic       UART_Rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_start = 0;
    int t_rise = 0;
    int rises = 0;
    int ferr_cycles = 0;
    logic valid_prev = 1'b0;
    logic [7:0] got_q[$];

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ovr;

    uart_rx #(.CLK_FREQ(50000000), .BAUD(115200)) dut (
        .clock_50MHz(clk),
        .reset(reset),
        .UART_Rx(UART_Rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ack(rx_ack),
        .overrun(overrun),
        .frame_err(frame_err),
        .busy(busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_err) ferr_cycles++;
        if (rx_valid && !valid_prev) begin
            rises++;
            t_rise = cyc;
        end
        valid_prev = rx_valid;
        if (rx_valid && rx_ack) got_q.push_back(rx_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int stop_len);
        t_start = cyc;
        UART_Rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            UART_Rx = b[i];
            tick(BIT);
        end
        UART_Rx = stop_bit;
        tick(stop_len);
        UART_Rx = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        tick(2);
    endtask

    function automatic void model_deliver(input logic [7:0] b);
        if (!m_valid) begin
            m_data = b;
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endfunction

    task automatic check_buf(input string tag);
        @(negedge clk);
        chk({tag, "_data"}, rx_data, m_data);
        chk({tag, "_valid"}, rx_valid, m_valid);
        chk({tag, "_ovr"}, overrun, m_ovr);
        tick(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_data"}, rx_data, 8'h00);
        chk({tag, "_valid"}, rx_valid, 1'b0);
        chk({tag, "_ovr"}, overrun, 1'b0);
        chk({tag, "_ferr"}, frame_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int r0, f0, n0, nb, dt;
        logic [7:0] b;
        reset = 1'b1;
        UART_Rx = 1'b1;
        rx_ack = 1'b0;
        m_data = 8'h00;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        tick(5);
        check_reset_outputs("rst");
        reset = 1'b0;
        tick(10);

        // Clean frame with latency check (~9.5 bit times from start edge)
        r0 = rises;
        f0 = ferr_cycles;
        send_byte(8'hA5, 1'b1, BIT);
        model_deliver(8'hA5);
        tick(5);
        check_buf("a5");
        chk("a5_rises", rises - r0, 1);
        chk("a5_ferr", ferr_cycles - f0, 0);
        dt = t_rise - t_start;
        chk("a5_latency", (dt >= 9 * BIT) && (dt <= 10 * BIT), 1'b1);
        ack_pulse();
        check_buf("a5_ack");

        // 100-clock glitch on an idle line
        r0 = rises;
        nb = 0;
        for (int i = 0; i < 700; i++) begin
            UART_Rx = (i < 100) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (busy) nb++;
            tick(1);
        end
        chk("glitch_busy_max", nb <= 217, 1'b1);
        chk("glitch_busy_seen", nb > 0, 1'b1);
        chk("glitch_rises", rises - r0, 0);
        chk("glitch_idle", busy, 1'b0);
        check_buf("glitch");

        // Framing error: stop bit low until well past its sample point
        r0 = rises;
        f0 = ferr_cycles;
        send_byte(8'h3C, 1'b0, 300);
        tick(2 * BIT);
        chk("ferr_pulse", ferr_cycles - f0, 1);
        chk("ferr_rises", rises - r0, 0);
        check_buf("ferr");

        // Overrun: two bytes without ack
        send_byte(8'h11, 1'b1, BIT);
        model_deliver(8'h11);
        send_byte(8'h22, 1'b1, BIT);
        model_deliver(8'h22);
        tick(5);
        check_buf("ovr");
        ack_pulse();
        check_buf("ovr_ack");

        // Ack held high: each byte appears as a single-cycle valid pulse
        r0 = rises;
        n0 = got_q.size();
        rx_ack = 1'b1;
        send_byte(8'h01, 1'b1, BIT);
        send_byte(8'hFF, 1'b1, BIT);
        send_byte(8'h80, 1'b1, BIT);
        tick(5);
        rx_ack = 1'b0;
        chk("ackh_count", got_q.size() - n0, 3);
        chk("ackh_rises", rises - r0, 3);
        if (got_q.size() - n0 >= 3) begin
            chk("ackh_b0", got_q[n0], 8'h01);
            chk("ackh_b1", got_q[n0 + 1], 8'hFF);
            chk("ackh_b2", got_q[n0 + 2], 8'h80);
        end
        m_data = 8'h80;
        m_valid = 1'b0;
        check_buf("ackh");

        // Reset during bit 4 of 0xF0, then a clean 0x5A
        send_byte(8'h11, 1'b1, BIT);
        model_deliver(8'h11);
        UART_Rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 4; i++) begin
            UART_Rx = 1'b0;
            tick(BIT);
        end
        UART_Rx = 1'b1;
        tick(200);
        reset = 1'b1;
        tick(3);
        check_reset_outputs("midrst");
        reset = 1'b0;
        m_data = 8'h00;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        r0 = rises;
        tick(5 * BIT);
        chk("midrst_nodeliver", rises - r0, 0);
        send_byte(8'h5A, 1'b1, BIT);
        model_deliver(8'h5A);
        tick(5);
        chk("midrst_rises", rises - r0, 1);
        check_buf("midrst_5a");
        ack_pulse();

        // Random bytes with random consumer acks
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1, BIT);
            model_deliver(b);
            tick(5);
            check_buf("rnd");
            if ($urandom_range(0, 1) == 1) begin
                ack_pulse();
                check_buf("rnd_ack");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
